pc_ctrl: RTL
============

// Module: pc_ctrl
// PURPOSE
//  Sequencer for the fetch stage. Drives the PC register write-enable and the 3-bit PC-source
//  select of the fetch-stage 8:1 PC mux. Also drives pipeline hold/flush controls.
//  Arbitrates simultaneous redirect requests from decode and pipe stages 2-5.
//  Applies load-use stalls and holds fetch for multi-cycle LM/SM instructions.
//  Sits between the hazard/forwarding logic and fetch, one per core.
// PARAMETERS
//  HOLD_W       4  width of multi-cycle hold counter and multi_cnt input
//  BOOT_CYCLES  1  cycles after reset with PC forced to 0 and pipe flushed (>=1)
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-high
//  redir_req    in   6       redirect requests; [0]=decode [1]=pipe2 [2]=pipe3 PC+1 [3]=pipe3 RF out [4]=pipe4 [5]=pipe5
//  stall_req    in   1       load-use stall from forwarding unit
//  multi_start  in   1       decode holds an LM/SM; qualified only in RUN
//  multi_cnt    in   HOLD_W  transfers for that LM/SM (0 treated as 1)
//  pc_write     out  1       PC register write enable
//  pc_sel       out  3       PC mux select: 0=zero 1=p3RF 2=PC+1 3=decode 4=p3PCinc 5=p2 6=p4 7=p5
//  hold_ifid    out  1       hold the IF/ID register
//  flush        out  5       flush[k]=1 clears pipe register k+1 (IF/ID = reg 1) at the next edge
//  busy         out  1       1 in BOOT or HOLD
// BEHAVIOUR
//  - State register only; all outputs are combinational from state and inputs (Mealy).
//    A request sampled in cycle N takes effect at edge N+1.
//  - States: BOOT, RUN, HOLD. Reset forces state=BOOT, boot counter=0, and hold counter=0.
//  - BOOT outputs: pc_write=1, pc_sel=0, flush=5'b11111, hold_ifid=0, busy=1; all inputs are ignored.
//    Move to RUN after BOOT_CYCLES cycles.
//  - Reset asserted mid-operation: immediate return to BOOT; any pending hold is discarded.
//  - Redirect, any state except BOOT:
//    - The highest set bit of redir_req wins (oldest stage).
//    - pc_sel follows: bit5->7, bit4->6, bit3->1, bit2->4, bit1->5, bit0->3.
//    - pc_write=1, hold_ifid=0.
//    - flush: bit0->00001, bit1->00011, bits2/3->00111, bit4->01111, bit5->11111.
//    - Next state=RUN; an active HOLD is aborted and its counter cleared.
//  - Redirect overrides stall_req and multi_start in the same cycle.
//  - RUN, no redirect, stall_req=1: pc_write=0, hold_ifid=1, flush=00010 (bubble into reg 2).
//    multi_start is ignored that cycle.
//  - RUN, no redirect, no stall, multi_start=1 with multi_cnt>1:
//    - Counter loads multi_cnt-1 and state goes to HOLD.
//    - This cycle is a normal advance: pc_write=1, pc_sel=2.
//    - multi_cnt of 0 or 1 causes no hold.
//  - RUN idle: pc_write=1, pc_sel=2, hold_ifid=0, flush=0.
//  - HOLD, no redirect: pc_write=0, pc_sel=2, hold_ifid=1, flush=0.
//    - Counter decrements each cycle; return to RUN in the cycle it reads 1.
//    - HOLD lasts exactly multi_cnt-1 cycles. stall_req adds no extra cycles.
//  - Counter arithmetic is unsigned HOLD_W-bit and never wraps below 0.
// CONFIGURATION
//  PC_CTRL_PERF_EN defined:
//    - Adds outputs redir_count[15:0] (cycles with a taken redirect) and stall_count[15:0]
//      (cycles with pc_write=0 outside BOOT).
//    - Both counters saturate at 16'hFFFF and clear on reset.
//  PC_CTRL_PERF_EN undefined: those ports and their counters do not exist; all other behaviour is identical.
// TESTING
//  - reset pulse, BOOT_CYCLES=1 -> one cycle pc_sel=0, pc_write=1, flush=11111, busy=1;
//    then RUN with pc_sel=2, pc_write=1.
//  - redir_req=6'b100011 in RUN -> pc_sel=7, flush=11111, pc_write=1.
//    Then redir_req=6'b001000 -> pc_sel=1, flush=00111.
//  - stall_req=1 with redir_req=0 -> pc_write=0, hold_ifid=1, flush=00010.
//    stall_req=1 with redir_req=6'b000001 -> pc_sel=3, pc_write=1, flush=00001.
//  - multi_start=1, multi_cnt=4 -> that cycle pc_write=1; next 3 cycles pc_write=0, hold_ifid=1, busy=1;
//    then RUN. multi_cnt=0 and multi_cnt=1 -> no HOLD.
//  - In HOLD with 2 cycles left, redir_req=6'b010000 -> pc_sel=6, flush=01111, next state RUN.
//    Reset asserted mid-HOLD -> BOOT outputs immediately.
//  - PC_CTRL_PERF_EN: 3 redirects and 5 stall cycles after BOOT -> redir_count=3, stall_count=5;
//    forced 70000 stalls -> stall_count stays at 16'hFFFF.

Source files
------------

// File: rtl/pc_ctrl.sv
// Fetch-stage PC sequencer: boot flush, redirect arbitration, load-use stall and LM/SM hold.
// Optional performance counters are enabled by defining PC_CTRL_PERF_EN.
module pc_ctrl #(
  parameter int HOLD_W      = 4,
  parameter int BOOT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        redir_req,
  input  logic              stall_req,
  input  logic              multi_start,
  input  logic [HOLD_W-1:0] multi_cnt,
  output logic              pc_write,
  output logic [2:0]        pc_sel,
  output logic              hold_ifid,
  output logic [4:0]        flush,
  output logic              busy
`ifdef PC_CTRL_PERF_EN
  ,
  output logic [15:0]       redir_count,
  output logic [15:0]       stall_count
`endif
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
  localparam logic [BOOT_W-1:0] BOOT_ONE  = BOOT_W'(1);
  localparam logic [HOLD_W-1:0] CNT_ONE   = HOLD_W'(1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [BOOT_W-1:0] r_boot_cnt;
  logic [BOOT_W-1:0] w_next_boot_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_next_hold_cnt;
  logic              w_redir;
  logic [2:0]        w_redir_sel;
  logic [4:0]        w_redir_flush;

  // Oldest requesting stage wins the PC mux.
  function automatic logic [2:0] redir_sel(input logic [5:0] req);
    logic [2:0] sel;
    casez (req)
      6'b1?????: sel = 3'd7;
      6'b01????: sel = 3'd6;
      6'b001???: sel = 3'd1;
      6'b0001??: sel = 3'd4;
      6'b00001?: sel = 3'd5;
      6'b000001: sel = 3'd3;
      default:   sel = 3'd2;
    endcase
    return sel;
  endfunction

  function automatic logic [4:0] redir_flush(input logic [5:0] req);
    logic [4:0] fl;
    casez (req)
      6'b1?????: fl = 5'b11111;
      6'b01????: fl = 5'b01111;
      6'b001???: fl = 5'b00111;
      6'b0001??: fl = 5'b00111;
      6'b00001?: fl = 5'b00011;
      6'b000001: fl = 5'b00001;
      default:   fl = 5'b00000;
    endcase
    return fl;
  endfunction

  assign w_redir       = |redir_req;
  assign w_redir_sel   = redir_sel(redir_req);
  assign w_redir_flush = redir_flush(redir_req);

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_BOOT;
      r_boot_cnt <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_boot_cnt <= w_next_boot_cnt;
      r_hold_cnt <= w_next_hold_cnt;
    end
  end

  // Next-state and counter update.
  always_comb begin
    w_next_state    = r_state;
    w_next_boot_cnt = r_boot_cnt;
    w_next_hold_cnt = r_hold_cnt;
    case (r_state)
      ST_BOOT: begin
        if (r_boot_cnt == BOOT_LAST) begin
          w_next_state    = ST_RUN;
          w_next_boot_cnt = '0;
        end else begin
          w_next_boot_cnt = r_boot_cnt + BOOT_ONE;
        end
      end
      ST_RUN: begin
        if (w_redir) begin
          w_next_hold_cnt = '0;
        end else if (!stall_req && multi_start && (multi_cnt > CNT_ONE)) begin
          w_next_state    = ST_HOLD;
          w_next_hold_cnt = multi_cnt - CNT_ONE;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_HOLD: begin
        // Counter reads the remaining hold cycles including the current one.
        if (w_redir || (r_hold_cnt <= CNT_ONE)) begin
          w_next_state    = ST_RUN;
          w_next_hold_cnt = '0;
        end else begin
          w_next_hold_cnt = r_hold_cnt - CNT_ONE;
        end
      end
      default: begin
        w_next_state    = ST_BOOT;
        w_next_boot_cnt = '0;
        w_next_hold_cnt = '0;
      end
    endcase
  end

  // Mealy output decode.
  always_comb begin
    pc_write  = 1'b1;
    pc_sel    = 3'd2;
    hold_ifid = 1'b0;
    flush     = 5'b00000;
    busy      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_redir) begin
          pc_sel = w_redir_sel;
          flush  = w_redir_flush;
        end else if (stall_req) begin
          pc_write  = 1'b0;
          hold_ifid = 1'b1;
          flush     = 5'b00010;
        end else begin
          pc_sel = 3'd2;
        end
      end
      ST_HOLD: begin
        busy = 1'b1;
        if (w_redir) begin
          pc_sel = w_redir_sel;
          flush  = w_redir_flush;
        end else begin
          pc_write  = 1'b0;
          hold_ifid = 1'b1;
        end
      end
      default: begin
        pc_sel = 3'd0;
        flush  = 5'b11111;
        busy   = 1'b1;
      end
    endcase
  end

`ifdef PC_CTRL_PERF_EN
  logic        w_active;
  logic [15:0] r_redir_count;
  logic [15:0] r_stall_count;

  assign w_active = (r_state == ST_RUN) || (r_state == ST_HOLD);

  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_redir_count <= 16'h0000;
      r_stall_count <= 16'h0000;
    end else begin
      if (w_active && w_redir && (r_redir_count != 16'hFFFF)) begin
        r_redir_count <= r_redir_count + 16'h0001;
      end
      if (w_active && !pc_write && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'h0001;
      end
    end
  end

  assign redir_count = r_redir_count;
  assign stall_count = r_stall_count;
`endif

endmodule
